// File: rtl/handshake_arbiter.sv
// Two-client four-phase handshake arbiter in front of a shared resource.
// All asynchronous inputs are synchronized; the FSM and every output are registered.
module handshake_arbiter #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       ack0,
    output logic       ack1,
    output logic       res_req,
    input  logic       res_ack,
    output logic       grant_id,
    output logic       busy,
    output logic [7:0] grant_count,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        StIdle,
        StResReq,
        StAck,
        StRelease
    } state_e;

    // Synchronizer chains; bit 0 is the first (metastability-exposed) stage.
    logic [SYNC_STAGES-1:0] req0_sync_q;
    logic [SYNC_STAGES-1:0] req1_sync_q;
    logic [SYNC_STAGES-1:0] res_ack_sync_q;

    logic req0_s;
    logic req1_s;
    logic res_ack_s;

    state_e     state_q, state_d;
    logic       grant_q, grant_d;
    logic       ptr_q, ptr_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       res_req_q, res_req_d;
    logic       busy_q, busy_d;
    logic [7:0] count_q, count_d;
    logic       err_q, err_d;

    logic       granted_req;
    logic       pick;

    // Shift each asynchronous input through its synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            req0_sync_q    <= '0;
            req1_sync_q    <= '0;
            res_ack_sync_q <= '0;
        end else begin
            req0_sync_q    <= {req0_sync_q[SYNC_STAGES-2:0], req0};
            req1_sync_q    <= {req1_sync_q[SYNC_STAGES-2:0], req1};
            res_ack_sync_q <= {res_ack_sync_q[SYNC_STAGES-2:0], res_ack};
        end
    end

    assign req0_s    = req0_sync_q[SYNC_STAGES-1];
    assign req1_s    = req1_sync_q[SYNC_STAGES-1];
    assign res_ack_s = res_ack_sync_q[SYNC_STAGES-1];

    // Next-state and registered-output decode for the handshake FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        res_req_d = res_req_q;
        busy_d    = busy_q;
        count_d   = count_q;
        err_d     = err_q;
        pick      = 1'b0;

        // Only the owner's request matters once a grant is held.
        granted_req = grant_q ? req1_s : req0_s;

        unique case (state_q)
            StIdle: begin
                if (req0_s || req1_s) begin
                    // Contention is settled by the pointer; otherwise the lone requester wins.
                    pick      = (req0_s && req1_s) ? ptr_q : req1_s;
                    grant_d   = pick;
                    state_d   = StResReq;
                    res_req_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            StResReq: begin
                if (res_ack_s) begin
                    if (granted_req) begin
                        state_d = StAck;
                        ack0_d  = ~grant_q;
                        ack1_d  = grant_q;
                    end else begin
                        // Owner withdrew before being acknowledged: unwind without an ack.
                        state_d   = StRelease;
                        res_req_d = 1'b0;
                        err_d     = 1'b1;
                    end
                end
            end

            StAck: begin
                if (!granted_req) begin
                    state_d   = StRelease;
                    ack0_d    = 1'b0;
                    ack1_d    = 1'b0;
                    res_req_d = 1'b0;
                end
            end

            StRelease: begin
                if (!res_ack_s) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    count_d = count_q + 8'd1;
                    // Hand priority to the client that just waited.
                    ptr_d   = ~grant_q;
                end
            end

            default: begin
                state_d   = StIdle;
                ack0_d    = 1'b0;
                ack1_d    = 1'b0;
                res_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= 1'b0;
            ptr_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            res_req_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            res_req_q <= res_req_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign res_req     = res_req_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign grant_count = count_q;
    assign proto_err   = err_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Self-checking bench for handshake_arbiter: directed scenarios plus randomized
// four-phase clients and resource checked against a transaction-level model.
module tb_handshake_arbiter;

    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, res_ack;
    logic       ack0, ack1, res_req, grant_id, busy, proto_err;
    logic [7:0] grant_count;

    int   n_cmp = 0;
    int   n_err = 0;
    logic ack1_seen = 1'b0;

    // Random-phase model state.
    logic [SYNC:0] h0, h1;
    logic          prev_busy, ptr_m, last_grant, exp_busy, exp_g;
    int            completions;

    handshake_arbiter #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .ack0        (ack0),
        .ack1        (ack1),
        .res_req     (res_req),
        .res_ack     (res_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .grant_count (grant_count),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    // Acks must be mutually exclusive in every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            assert (!(ack0 && ack1)) else begin
                n_err++;
                $error("FAIL ack_mutex: observed ack0=%0b ack1=%0b required not both 1", ack0, ack1);
            end
            if (ack1) ack1_seen = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return res_req;
            1:       return ack0;
            2:       return ack1;
            3:       return busy;
            default: return proto_err;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            step(1);
            if (sig(sel) === val) hit = 1'b1;
        end
        n_cmp++;
        assert (hit) else begin
            n_err++;
            $error("FAIL %s: timeout on signal %0d, observed %0b expected %0b",
                   tag, sel, sig(sel), val);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req0    = 1'b0;
        req1    = 1'b0;
        res_ack = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Complete one four-phase cycle for client c, acting as the resource.
    task automatic handshake(input logic c, input bit reraise, input string tag);
        wait_for(0, 1'b1, {tag, "_resreq_up"});
        check({tag, "_gid"}, {7'd0, grant_id}, {7'd0, c});
        res_ack = 1'b1;
        wait_for(1 + int'(c), 1'b1, {tag, "_ack_up"});
        if (c) req1 = 1'b0; else req0 = 1'b0;
        wait_for(1 + int'(c), 1'b0, {tag, "_ack_down"});
        check({tag, "_resreq_down"}, {7'd0, res_req}, 8'd0);
        if (reraise) begin
            if (c) req1 = 1'b1; else req0 = 1'b1;
        end
        res_ack = 1'b0;
        wait_for(3, 1'b0, {tag, "_idle"});
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_ack0", {7'd0, ack0}, 8'd0);
        check("rst_ack1", {7'd0, ack1}, 8'd0);
        check("rst_resreq", {7'd0, res_req}, 8'd0);
        check("rst_gid", {7'd0, grant_id}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_count", grant_count, 8'd0);
        check("rst_perr", {7'd0, proto_err}, 8'd0);

        // Single-client latency: SYNC+1 edges from each input change
        req0 = 1'b1;
        step(2);
        check("lat_resreq_e2", {7'd0, res_req}, 8'd0);
        step(1);
        check("lat_resreq_e3", {7'd0, res_req}, 8'd1);
        check("lat_busy_e3", {7'd0, busy}, 8'd1);
        check("lat_gid", {7'd0, grant_id}, 8'd0);
        res_ack = 1'b1;
        step(2);
        check("lat_ack_e2", {7'd0, ack0}, 8'd0);
        step(1);
        check("lat_ack_e3", {7'd0, ack0}, 8'd1);
        req0 = 1'b0;
        step(2);
        check("lat_ackhold_e2", {7'd0, ack0}, 8'd1);
        step(1);
        check("lat_ackdrop_e3", {7'd0, ack0}, 8'd0);
        check("lat_resreqdrop_e3", {7'd0, res_req}, 8'd0);
        check("lat_busyrel", {7'd0, busy}, 8'd1);
        res_ack = 1'b0;
        step(2);
        check("lat_busy_e2", {7'd0, busy}, 8'd1);
        step(1);
        check("lat_busy_e3", {7'd0, busy}, 8'd0);
        check("lat_count", grant_count, 8'd1);

        // Simultaneous requests after reset: client 0 first, then pending client 1
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        handshake(1'b0, 1'b0, "simul0");
        handshake(1'b1, 1'b0, "simul1");
        check("simul_count", grant_count, 8'd2);

        // Fairness with both clients re-requesting immediately
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) handshake(logic'(i % 2), 1'b1, "fair");
        check("fair_count", grant_count, 8'd6);

        // Protocol error: client 1 withdraws before the resource acknowledges
        do_reset();
        ack1_seen = 1'b0;
        req1 = 1'b1;
        wait_for(0, 1'b1, "perr_resreq_up");
        req1 = 1'b0;
        step(1);
        res_ack = 1'b1;
        wait_for(0, 1'b0, "perr_resreq_down");
        check("perr_flag", {7'd0, proto_err}, 8'd1);
        check("perr_busy", {7'd0, busy}, 8'd1);
        res_ack = 1'b0;
        wait_for(3, 1'b0, "perr_idle");
        check("perr_count", grant_count, 8'd1);
        step(5);
        check("perr_sticky", {7'd0, proto_err}, 8'd1);
        check("perr_no_ack1", {7'd0, ack1_seen}, 8'd0);

        // Reset in ACK state after the pointer has moved to client 1
        do_reset();
        req0 = 1'b1;
        handshake(1'b0, 1'b0, "pre");
        req0 = 1'b1;
        wait_for(0, 1'b1, "midrst_resreq");
        res_ack = 1'b1;
        wait_for(1, 1'b1, "midrst_ack0");
        rst     = 1'b1;
        req0    = 1'b0;
        res_ack = 1'b0;
        step(1);
        check("midrst_ack0_0", {7'd0, ack0}, 8'd0);
        check("midrst_ack1_0", {7'd0, ack1}, 8'd0);
        check("midrst_resreq_0", {7'd0, res_req}, 8'd0);
        check("midrst_busy_0", {7'd0, busy}, 8'd0);
        check("midrst_gid_0", {7'd0, grant_id}, 8'd0);
        check("midrst_count_0", grant_count, 8'd0);
        check("midrst_perr_0", {7'd0, proto_err}, 8'd0);
        rst  = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        handshake(1'b0, 1'b0, "midrst_ptr");
        handshake(1'b1, 1'b0, "midrst_req1");
        check("midrst_count", grant_count, 8'd2);

        // Counter wrap after 256 grants
        do_reset();
        for (int i = 0; i < 256; i++) begin
            req0 = 1'b1;
            handshake(1'b0, 1'b0, "wrap");
            if (i == 254) check("wrap_255", grant_count, 8'd255);
        end
        check("wrap_count", grant_count, 8'd0);
        check("wrap_perr", {7'd0, proto_err}, 8'd0);
        check("wrap_busy", {7'd0, busy}, 8'd0);

        // Randomized compliant clients and resource against the grant model
        do_reset();
        h0          = '0;
        h1          = '0;
        prev_busy   = 1'b0;
        ptr_m       = 1'b0;
        last_grant  = 1'b0;
        completions = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step(1);
            // Requests reach the arbiter's decision SYNC edges after being sampled.
            h0 = {h0[SYNC-1:0], req0};
            h1 = {h1[SYNC-1:0], req1};
            if (!prev_busy) begin
                exp_busy = h0[SYNC] | h1[SYNC];
                check("rnd_busy", {7'd0, busy}, {7'd0, exp_busy});
                if (exp_busy && busy) begin
                    exp_g = (h0[SYNC] && h1[SYNC]) ? ptr_m : h1[SYNC];
                    check("rnd_gid", {7'd0, grant_id}, {7'd0, exp_g});
                    check("rnd_resreq", {7'd0, res_req}, 8'd1);
                    last_grant = exp_g;
                end
            end else if (!busy) begin
                completions++;
                ptr_m = ~last_grant;
                check("rnd_count", grant_count, completions[7:0]);
            end
            if (ack0) check("rnd_ack0_owner", {7'd0, grant_id}, 8'd0);
            if (ack1) check("rnd_ack1_owner", {7'd0, grant_id}, 8'd1);
            prev_busy = busy;

            if (req0 && ack0 && $urandom_range(0, 1) == 0) req0 = 1'b0;
            else if (!req0 && !ack0 && $urandom_range(0, 3) == 0) req0 = 1'b1;
            if (req1 && ack1 && $urandom_range(0, 1) == 0) req1 = 1'b0;
            else if (!req1 && !ack1 && $urandom_range(0, 3) == 0) req1 = 1'b1;
            if (res_req && !res_ack && $urandom_range(0, 2) == 0) res_ack = 1'b1;
            else if (!res_req && res_ack && $urandom_range(0, 2) == 0) res_ack = 1'b0;
        end
        check("rnd_perr", {7'd0, proto_err}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on each asynchronous input (legal range 2..4).
REQ-003 Port clk  input  1  rising-edge system clock.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port req0  input  1  client 0 four-phase request (asynchronous).
REQ-006 Port req1  input  1  client 1 four-phase request (asynchronous).
REQ-007 Port ack0  output  1  client 0 four-phase acknowledge (registered).
REQ-008 Port ack1  output  1  client 1 four-phase acknowledge (registered).
REQ-009 Port res_req  output  1  request to the downstream shared resource/C-element join stage (registered).
REQ-010 Port res_ack  input  1  resource acknowledge (asynchronous).
REQ-011 Port grant_id  output  1  client owning the current grant; valid while busy=1.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port grant_count  output  8  completed grants, modulo 256.
REQ-014 Port proto_err  output  1  sticky flag: granted client dropped its request before being acknowledged.

Function
REQ-015 req0, req1 and res_ack SHALL each pass through a SYNC_STAGES-deep flip-flop chain; the FSM SHALL use only the synchronized versions (req0_s, req1_s, res_ack_s).
REQ-016 FSM states SHALL be IDLE, RES_REQ, ACK, RELEASE.
REQ-017 IDLE: if exactly one req_s is high, grant that client; if both are high, grant the client selected by the priority pointer; next state RES_REQ, with res_req=1 and grant_id set at that same edge.
REQ-018 RES_REQ: hold res_req=1; on res_ack_s=1 go to ACK and assert the granted ack.
REQ-019 RES_REQ: if the granted req_s is 0 when res_ack_s=1, go directly to RELEASE without asserting any ack, and set proto_err.
REQ-020 ACK: hold the granted ack=1 and res_req=1; on the granted req_s=0, go to RELEASE and deassert ack and res_req at the same edge.
REQ-021 RELEASE: hold ack=0 and res_req=0; on res_ack_s=0 go to IDLE, increment grant_count (wrap 255->0), and set the priority pointer to the non-granted client.
REQ-022 At most one of ack0/ack1 SHALL be high in any cycle; ack SHALL be high only in ACK state.
REQ-023 The non-granted client's request SHALL remain pending, never dropped, and SHALL be served on the next IDLE evaluation.
REQ-024 Latency: with all other conditions met, an edge on any asynchronous input SHALL be reflected on the registered outputs SYNC_STAGES+1 clock edges after it is first sampled.
REQ-025 Requests of the non-granted client SHALL NOT change state, outputs or the pointer while busy=1.
REQ-026 The IDLE->RES_REQ decision SHALL be taken from the same-cycle req0_s/req1_s pair; there SHALL be no back-to-back grant without passing through IDLE for at least one cycle.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state=IDLE, ack0=ack1=res_req=0, grant_id=0, busy=0, grant_count=0, proto_err=0, priority pointer=client 0, and all synchronizer flops to 0.
REQ-028 Reset asserted mid-handshake SHALL abort the handshake with the above values; the downstream stage SHALL observe res_req fall without a completed cycle.

Verification
REQ-029 Single client, SYNC_STAGES=2: req0 rises -> res_req=1 on the 3rd edge; res_ack rises -> ack0=1 3 edges later; req0 falls -> ack0=0 and res_req=0 3 edges later; res_ack falls -> busy=0 and grant_count=1.
REQ-030 Simultaneous requests after reset: req0=req1=1 in the same cycle -> client 0 granted (grant_id=0); after completion, client 1 is granted next with no new req1 edge; grant_count=2.
REQ-031 Fairness: both requests held permanently, 6 full cycles -> grant_id sequence 0,1,0,1,0,1; ack0 and ack1 never high together.
REQ-032 Protocol error: req1 raised, then dropped before res_ack -> ack1 never asserted, proto_err=1 stays set, FSM returns to IDLE, grant_count increments.
REQ-033 Reset mid-operation: rst pulsed in ACK state -> next edge all outputs 0, grant_count=0, priority to client 0; a following req1 is served normally.
REQ-034 Counter wrap: 256 completed grants -> grant_count returns to 0, with no other side effects.
